// File: rtl/ir_fetch_ctrl.sv
// Instruction-fetch sequencer: owns program memory and PC, feeds the instruction
// register over the shared OP+ADDR tri-state bus and reloads PC on jumps.
module ir_fetch_ctrl #(
    parameter int OP_W   = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   prog_we,
    input  logic [ADDR_W-1:0]      prog_addr,
    input  logic [OP_W+ADDR_W-1:0] prog_data,
    input  logic                   exec_done,
    input  logic                   jump,
    inout  wire  [OP_W+ADDR_W-1:0] data,
    output logic                   ir_load,
    output logic                   ir_valid,
    output logic [ADDR_W-1:0]      pc,
    output logic                   busy
);

    localparam int DW = OP_W + ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_JUMP  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic              halt_pend_r;
    logic              halt_any_s;
    logic              mem_we_s;
    logic              ir_load_r;
    logic              ir_valid_r;
    logic              drive_r;
    logic              busy_r;
    logic [DW-1:0]     rd_word_s;
    logic              unused_op_s;
    logic [DW-1:0]     mem [0:DEPTH-1];

    // Addresses fold into the populated part of the memory
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W:0] a);
        return ADDR_W'(32'(a) % 32'(DEPTH));
    endfunction

    assign rd_word_s   = mem[pc_r];
    assign data        = drive_r ? rd_word_s : {DW{1'bz}};
    assign unused_op_s = ^data[DW-1:ADDR_W];

    assign ir_load  = ir_load_r;
    assign ir_valid = ir_valid_r;
    assign pc       = pc_r;
    assign busy     = busy_r;

    // Next-state, PC update and program-write decode
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        mem_we_s   = 1'b0;
        halt_any_s = halt | halt_pend_r;
        case (state_r)
            S_IDLE: begin
                if (prog_we) begin
                    mem_we_s = (32'(prog_addr) < 32'(DEPTH));
                end else begin
                    mem_we_s = 1'b0;
                end
                if (start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: state_s = S_LOAD;
            S_LOAD:  state_s = S_EXEC;
            S_EXEC: begin
                if (exec_done && jump) begin
                    state_s = S_JUMP;
                end else if (exec_done) begin
                    pc_s    = wrap_addr({1'b0, pc_r} + {{ADDR_W{1'b0}}, 1'b1});
                    state_s = halt_any_s ? S_IDLE : S_FETCH;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_JUMP: begin
                // Instruction register owns the bus now; its ADDR field is the target
                pc_s    = wrap_addr({1'b0, data[ADDR_W-1:0]});
                state_s = halt_any_s ? S_IDLE : S_FETCH;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, PC, pending halt and registered bus-control outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= S_IDLE;
            pc_r        <= {ADDR_W{1'b0}};
            halt_pend_r <= 1'b0;
            ir_load_r   <= 1'b0;
            ir_valid_r  <= 1'b0;
            drive_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_load_r  <= (state_s == S_LOAD);
            ir_valid_r <= (state_s == S_JUMP);
            drive_r    <= (state_s == S_FETCH) || (state_s == S_LOAD);
            busy_r     <= (state_s != S_IDLE);
            if (state_s == S_IDLE) begin
                halt_pend_r <= 1'b0;
            end else if ((state_r != S_IDLE) && halt) begin
                halt_pend_r <= 1'b1;
            end else begin
                halt_pend_r <= halt_pend_r;
            end
        end
    end

    // Program memory write port, not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Self-checking bench for ir_fetch_ctrl: models the instruction register on the
// bus and scoreboards each expected fetched word against the captured one.
module tb_ir_fetch_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = 8'h00;
    logic [15:0] prog_data = 16'h0000;
    logic        exec_done = 1'b0;
    logic        jump = 1'b0;
    wire  [15:0] data;
    logic        ir_load;
    logic        ir_valid;
    logic [7:0]  pc;
    logic        busy;

    logic [15:0] ir_word = 16'h0000;
    logic        probe_en = 1'b0;
    logic [15:0] tb_mem [0:255];
    logic [15:0] sbq [$];
    logic [15:0] exp_word;
    logic [7:0]  exp_pc = 8'h00;
    int          errors = 0;
    int          checks = 0;

    // IR model drives the bus in JUMP; probe pulls it to zero to prove release
    assign data = ir_valid ? ir_word : (probe_en ? 16'h0000 : 16'hzzzz);

    ir_fetch_ctrl #(.OP_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .halt      (halt),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .exec_done (exec_done),
        .jump      (jump),
        .data      (data),
        .ir_load   (ir_load),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d; tb_mem[a] = d;
        step;
        prog_we = 1'b0;
    endtask

    // Entered FETCH one edge ago: FETCH, LOAD, then settle in EXEC
    task automatic fetch_seq(input string name, input logic halt_in_fetch);
        halt = halt_in_fetch;
        checks++;
        if (pc !== exp_pc || busy !== 1'b1)
            begin errors++; $display("FAIL %s_fetch_pc: pc=%h busy=%b, want pc=%h busy=1", name, pc, busy, exp_pc); end
        checks++;
        if (data !== tb_mem[exp_pc] || ir_load !== 1'b0)
            begin errors++; $display("FAIL %s_fetch_data: data=%h ir_load=%b, want %h/0", name, data, ir_load, tb_mem[exp_pc]); end
        step;
        halt = 1'b0;
        checks++;
        if (sbq.size() == 0) begin
            errors++; $display("FAIL %s_load_sb: scoreboard empty at ir_load=%b", name, ir_load);
        end else begin
            exp_word = sbq.pop_front();
            if (ir_load !== 1'b1 || data !== exp_word)
                begin errors++; $display("FAIL %s_load: ir_load=%b data=%h, want 1/%h", name, ir_load, data, exp_word); end
        end
        step;
        probe_en = 1'b1;
        #1;
        checks++;
        if (ir_load !== 1'b0 || ir_valid !== 1'b0 || data !== 16'h0000)
            begin errors++; $display("FAIL %s_exec: ir_load=%b ir_valid=%b bus=%h, want 0/0/released", name, ir_load, ir_valid, data); end
        probe_en = 1'b0;
    endtask

    task automatic retire_next;
        exec_done = 1'b1; jump = 1'b0;
        exp_pc = exp_pc + 8'd1;
        sbq.push_back(tb_mem[exp_pc]);
        step;
        exec_done = 1'b0;
    endtask

    // From EXEC: branch through JUMP with the IR model presenting w
    task automatic take_jump(input string name, input logic [15:0] w, input logic h);
        ir_word = w; exec_done = 1'b1; jump = 1'b1; halt = h;
        step;
        exec_done = 1'b0; jump = 1'b0; halt = 1'b0;
        checks++;
        if (ir_valid !== 1'b1 || ir_load !== 1'b0)
            begin errors++; $display("FAIL %s_ir_valid: ir_valid=%b ir_load=%b, want 1/0", name, ir_valid, ir_load); end
        checks++;
        if (data !== w)
            begin errors++; $display("FAIL %s_bus: data=%h, want %h (contention)", name, data, w); end
        checks++;
        if (pc !== exp_pc)
            begin errors++; $display("FAIL %s_pc_held: pc=%h, want %h", name, pc, exp_pc); end
        exp_pc = w[7:0];
        if (!h) sbq.push_back(tb_mem[exp_pc]);
        step;
        checks++;
        if (ir_valid !== 1'b0 || pc !== exp_pc)
            begin errors++; $display("FAIL %s_exit: ir_valid=%b pc=%h, want 0/%h", name, ir_valid, pc, exp_pc); end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        #12;
        probe_en = 1'b1;
        #1;
        checks++;
        if (pc !== 8'h00 || ir_load !== 1'b0 || ir_valid !== 1'b0 || busy !== 1'b0 || data !== 16'h0000)
            begin errors++; $display("FAIL reset: pc=%h ir_load=%b ir_valid=%b busy=%b bus=%h", pc, ir_load, ir_valid, busy, data); end
        probe_en = 1'b0;
        nrst = 1'b1;
        step;
    endtask

    task automatic test_basic_fetch;
        prog(8'h00, 16'h0A0F);
        prog(8'h01, 16'h0B10);
        prog(8'h2A, 16'h1234);
        prog(8'hFF, 16'h55AA);
        prog(8'h02, 16'h2222);
        exp_pc = 8'h00;
        start = 1'b1;
        sbq.push_back(tb_mem[exp_pc]);
        step;
        start = 1'b0;
        fetch_seq("first", 1'b0);
        retire_next;
        fetch_seq("second", 1'b0);
    endtask

    task automatic test_jump;
        take_jump("jump", 16'h0F2A, 1'b0);
        fetch_seq("jump_target", 1'b0);
    endtask

    task automatic test_wrap;
        take_jump("to_ff", 16'h00FF, 1'b0);
        fetch_seq("pc_ff", 1'b0);
        retire_next;
        fetch_seq("wrap", 1'b0);
    endtask

    task automatic test_halt;
        retire_next;
        fetch_seq("halt_fetch", 1'b1);
        prog_we = 1'b1; prog_addr = 8'h02; prog_data = 16'hDEAD;
        step;
        prog_we = 1'b0;
        exec_done = 1'b1; jump = 1'b0;
        exp_pc = exp_pc + 8'd1;
        step;
        exec_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            probe_en = 1'b1;
            #1;
            checks++;
            if (busy !== 1'b0 || ir_load !== 1'b0 || pc !== exp_pc || data !== 16'h0000)
                begin errors++; $display("FAIL halt_idle%0d: busy=%b ir_load=%b pc=%h bus=%h, want 0/0/%h/released", i, busy, ir_load, pc, data, exp_pc); end
            probe_en = 1'b0;
            step;
        end
        start = 1'b1;
        sbq.push_back(tb_mem[exp_pc]);
        step;
        start = 1'b0;
        fetch_seq("after_halt", 1'b0);
    endtask

    task automatic test_halt_jump;
        take_jump("halt_jump", 16'h0003, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || ir_load !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'h03)
                begin errors++; $display("FAIL halt_jump_idle%0d: busy=%b ir_load=%b ir_valid=%b pc=%h, want 0/0/0/03", i, busy, ir_load, ir_valid, pc); end
            step;
        end
    endtask

    task automatic test_prog_start_and_reset;
        prog_we = 1'b1; prog_addr = 8'h03; prog_data = 16'h3333; tb_mem[8'h03] = 16'h3333;
        start = 1'b1;
        sbq.push_back(tb_mem[exp_pc]);
        step;
        prog_we = 1'b0; start = 1'b0;
        checks++;
        if (data !== 16'h3333)
            begin errors++; $display("FAIL write_start_fetch: data=%h, want 3333", data); end
        step;
        checks++;
        exp_word = sbq.pop_front();
        if (ir_load !== 1'b1 || data !== exp_word || pc !== 8'h03)
            begin errors++; $display("FAIL write_start_load: ir_load=%b data=%h pc=%h, want 1/%h/03", ir_load, data, pc, exp_word); end
        #2;
        nrst = 1'b0;
        probe_en = 1'b1;
        #1;
        checks++;
        if (pc !== 8'h00 || ir_load !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0 || data !== 16'h0000)
            begin errors++; $display("FAIL reset_mid_load: pc=%h ir_load=%b busy=%b ir_valid=%b bus=%h", pc, ir_load, busy, ir_valid, data); end
        probe_en = 1'b0;
        step;
        nrst = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_jump;
        test_wrap;
        test_halt;
        test_halt_jump;
        test_prog_start_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_fetch_ctrl.md
Name: ir_fetch_ctrl

Overview:
- Instruction-fetch sequencer on the shared `OP+ADDR` data bus; it is the other end of the instruction register's bus protocol.
- Holds a small program memory and the program counter.
- Drives the fetched word onto the tri-state bus and pulses `ir_load` so the instruction register captures it.
- For jumps, releases the bus, asserts `ir_valid` so the instruction register drives the bus, and samples the ADDR field as the new PC.

Parameters:
- `OP_W`, 8, opcode field width (upper bits of a bus word).
- `ADDR_W`, 8, address field width (lower bits); also the PC width.
- `DEPTH`, 256, program memory words; must be ≤ 2**ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous reset, active low.
- `start`  in  1  begin fetching from the current PC (honoured in IDLE only).
- `halt`  in  1  stop after the current instruction completes.
- `prog_we`  in  1  program memory write strobe (honoured in IDLE only).
- `prog_addr`  in  `ADDR_W`  program memory write address.
- `prog_data`  in  `OP_W+ADDR_W`  program memory write data.
- `exec_done`  in  1  execute unit has finished the current instruction.
- `jump`  in  1  qualifies `exec_done`: the instruction is a branch to the IR address field.
- `data`  inout  `OP_W+ADDR_W`  shared tri-state bus to the instruction register.
- `ir_load`  out  1  instruction register captures `data` at this edge.
- `ir_valid`  out  1  instruction register drives `data` this cycle.
- `pc`  out  `ADDR_W`  current program counter.
- `busy`  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (`nrst` low, asynchronous, any state):
  - state = IDLE, `pc` = 0, `ir_load` = 0, `ir_valid` = 0, `busy` = 0, `data` released (all Z).
  - Program memory contents are not reset.
- Bus ownership:
  - This block drives `data` only in FETCH and LOAD.
  - `ir_valid` is high only in JUMP.
  - This block and the instruction register never drive the bus in the same cycle.
  - Every other state leaves `data` at Z.
- All outputs are registered/decoded from state; no combinational input-to-output paths.
- IDLE:
  - `prog_we` = 1 writes `mem[prog_addr]` <= `prog_data`.
  - `start` = 1 goes to FETCH.
  - If `prog_we` and `start` are both high, the write happens and the state goes to FETCH; the fetch reads the memory value after that edge.
- FETCH (1 cycle): drive `data` = `mem[pc]`; go to LOAD.
- LOAD (1 cycle): keep driving `mem[pc]` and set `ir_load` = 1; the instruction register captures at the end of this cycle; go to EXEC.
- Fetch latency: the instruction register holds `mem[pc]` 2 cycles after leaving IDLE or JUMP.
- EXEC (bus released) waits for `exec_done`:
  - `exec_done` with `jump` = 0: `pc` <= `pc+1`, wrapping modulo `DEPTH`.
  - `exec_done` with `jump` = 1: go to JUMP, `pc` unchanged.
  - Then, if `halt` is high, go to IDLE; otherwise go to FETCH (non-jump case).
  - `halt` with a jump: the jump still completes through JUMP, then the block goes to IDLE.
  - `jump` without `exec_done` is ignored.
- JUMP (1 cycle): `ir_valid` = 1; at the edge `pc` <= `data[ADDR_W-1:0]` mod `DEPTH`; go to FETCH, or to IDLE if a halt is pending.
- Halt is latched:
  - Latched on a `halt` pulse in any non-IDLE state.
  - Acted on at the next instruction boundary (EXEC exit or JUMP exit).
  - Cleared on entering IDLE.
- Outside IDLE: `prog_we` is ignored and `start` is ignored.

Test Plan:
- Reset with `pc` nonzero mid-LOAD → `pc` = 0, `ir_load` = 0, `data` = Z, `busy` = 0 immediately, with no clock edge needed.
- Program `mem[0]` = 16'h0A0F and `mem[1]` = 16'h0B10, pulse `start` → `data` = 16'h0A0F in FETCH and LOAD, `ir_load` high 1 cycle; `exec_done` → `pc` = 1, then 16'h0B10 is fetched.
- `pc` = 255 with `DEPTH` = 256, `exec_done` with no jump → `pc` = 0, fetch of `mem[0]`.
- In EXEC, `exec_done` + `jump` while the IR model drives 16'h0F2A during `ir_valid` → exactly 1 cycle of `ir_valid`, never overlapping a block drive, `pc` = 8'h2A, next fetch reads `mem[0x2A]`.
- `halt` pulsed during FETCH → the instruction completes, IDLE entered after `exec_done`, `pc` incremented, `busy` = 0; `prog_we` pulses during EXEC leave memory unchanged.
- `halt` + jump together → JUMP executes, `pc` = the loaded address, the block returns to IDLE with no further fetch.
